// File: rtl/xpb_csa_accumulator.sv
// rtl/xpb_csa_accumulator.sv - carry-save accumulator folding XPB table lanes into a redundant (sum, carry) pair
module xpb_csa_accumulator #(
    parameter int  WORD_W = 1024,
    parameter int  LANES  = 2,
    parameter int  GUARD  = 8,
    localparam int AW     = WORD_W + GUARD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*WORD_W-1:0]   in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AW-1:0]             out_sum,
    output logic [AW-1:0]             out_carry,
    output logic [15:0]               out_terms,
    output logic                      out_ovf
);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   sum_q, sum_d;
    logic [AW-1:0]   carry_q, carry_d;
    logic [15:0]     terms_q, terms_d;
    logic            ovf_q, ovf_d;

    logic [AW-1:0]   csa_s, csa_c, lane;
    logic [16:0]     terms_inc;
    logic            accept;

    assign accept    = in_valid & in_ready_q;
    assign terms_inc = {1'b0, terms_q} + 17'(LANES);

    // One 3:2 compressor per lane; the carry is shifted into weight 2^(i+1) here.
    always_comb begin
        csa_s = sum_q;
        csa_c = carry_q;
        lane  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane  = AW'(in_data[k*WORD_W +: WORD_W]);
            {csa_s, csa_c} = {csa_s ^ csa_c ^ lane,
                              ((csa_s & csa_c) | (csa_s & lane) | (csa_c & lane)) << 1};
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        terms_d = terms_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    sum_d   = csa_s;
                    carry_d = csa_c;
                    terms_d = terms_inc[16] ? 16'hFFFF : terms_inc[15:0];
                    if (terms_inc > 17'((1 << GUARD) - 1)) begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                    sum_d   = '0;
                    carry_d = '0;
                    terms_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase
        // Handshake flags are registered so in_ready stays low until the first edge out of reset.
        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            terms_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            terms_q     <= terms_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_terms = terms_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_xpb_csa_accumulator.sv
// tb/tb_xpb_csa_accumulator.sv - directed table-driven bench for xpb_csa_accumulator
module tb_xpb_csa_accumulator;

    localparam int WORD_W = 1024;
    localparam int LANES  = 2;
    localparam int GUARD  = 8;
    localparam int AW     = WORD_W + GUARD;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*WORD_W-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [AW-1:0]           out_sum;
    logic [AW-1:0]           out_carry;
    logic [15:0]             out_terms;
    logic                    out_ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WORD_W-1:0] l0;
        logic [WORD_W-1:0] l1;
        logic [AW-1:0]     exp;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    xpb_csa_accumulator #(.WORD_W(WORD_W), .LANES(LANES), .GUARD(GUARD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_terms (out_terms),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
                     name, got[AW-1:AW-32], got[31:0], exp[AW-1:AW-32], exp[31:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [WORD_W-1:0] l0, input logic [WORD_W-1:0] l1, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = {l1, l0};
        in_last  = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", AW'(in_ready), AW'(1));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [AW-1:0] exp_total,
                                input logic [15:0] exp_terms, input logic exp_ovf);
        logic [AW-1:0] tot;
        tot = out_sum + out_carry;
        chk({name, "_out_valid"}, AW'(out_valid), AW'(1));
        chk({name, "_sum"}, tot, exp_total);
        chk({name, "_terms"}, AW'(out_terms), AW'(exp_terms));
        chk({name, "_ovf"}, AW'(out_ovf), AW'(exp_ovf));
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_drain_valid"}, AW'(out_valid), AW'(0));
        chk({name, "_drain_ready"}, AW'(in_ready), AW'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0]     one_aw;
        logic [AW-1:0]     six_aw;
        logic [WORD_W-1:0] ones;
        logic [WORD_W-1:0] tv;
        logic [AW-1:0]     exp_tot;

        one_aw = AW'(1);
        six_aw = AW'(6);
        ones   = '1;

        vecs[0] = '{l0: WORD_W'(1), l1: WORD_W'(1), exp: AW'(2)};
        vecs[1] = '{l0: WORD_W'(7), l1: WORD_W'(9), exp: AW'(16)};
        vecs[2] = '{l0: ones, l1: WORD_W'(1), exp: one_aw << WORD_W};
        vecs[3] = '{l0: ones, l1: ones, exp: (one_aw << (WORD_W + 1)) - AW'(2)};
        vecs[4] = '{l0: '0, l1: '0, exp: '0};
        vecs[5] = '{l0: WORD_W'(1) << (WORD_W - 1), l1: WORD_W'(1) << (WORD_W - 1), exp: one_aw << WORD_W};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", AW'(in_ready), AW'(0));
        chk("rst_out_valid", AW'(out_valid), AW'(0));
        chk("rst_sum", out_sum, '0);
        chk("rst_carry", out_carry, '0);
        chk("rst_terms", AW'(out_terms), AW'(0));
        chk("rst_ovf", AW'(out_ovf), AW'(0));
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", AW'(in_ready), AW'(0));
        tick();
        chk("ready_after_edge", AW'(in_ready), AW'(1));

        for (int i = 0; i < 6; i++) begin
            send_beat(vecs[i].l0, vecs[i].l1, 1'b1);
            check_result($sformatf("vec%0d", i), vecs[i].exp, 16'd2, 1'b0);
            consume($sformatf("vec%0d", i));
        end

        for (int b = 0; b < 3; b++) send_beat(ones, ones, b == 2);
        check_result("allones3", (six_aw << WORD_W) - six_aw, 16'd6, 1'b0);
        consume("allones3");

        for (int i = 0; i < WORD_W / 32; i++) tv[i*32 +: 32] = 32'h9E3779B9 * (i + 1);
        for (int b = 0; b < 4; b++) send_beat(tv, tv, b == 3);
        check_result("xpb_idx1", AW'(tv) << 3, 16'd8, 1'b0);
        consume("xpb_idx1");

        send_beat(WORD_W'(3), WORD_W'(4), 1'b1);
        check_result("hold_first", AW'(7), 16'd2, 1'b0);
        in_valid = 1'b1;
        in_data  = {WORD_W'(11), WORD_W'(10)};
        in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold%0d_ready", c), AW'(in_ready), AW'(0));
            chk($sformatf("hold%0d_sum", c), out_sum + out_carry, AW'(7));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_drain_valid", AW'(out_valid), AW'(0));
        chk("hold_drain_ready", AW'(in_ready), AW'(1));
        chk("hold_drain_terms", AW'(out_terms), AW'(0));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("hold_next", AW'(21), 16'd2, 1'b0);
        consume("hold_next");

        for (int b = 0; b < 128; b++) begin
            send_beat(WORD_W'(1), WORD_W'(1), b == 127);
            if (b == 126) begin
                chk("ovf_at_254_terms", AW'(out_terms), AW'(254));
                chk("ovf_at_254_flag", AW'(out_ovf), AW'(0));
            end
        end
        check_result("ovf256", AW'(256), 16'd256, 1'b1);
        consume("ovf256");
        send_beat(WORD_W'(2), WORD_W'(3), 1'b1);
        check_result("after_ovf", AW'(5), 16'd2, 1'b0);
        consume("after_ovf");

        send_beat(WORD_W'(5), WORD_W'(5), 1'b0);
        send_beat(WORD_W'(5), WORD_W'(5), 1'b0);
        chk("abort_partial_terms", AW'(out_terms), AW'(4));
        rst_n = 1'b0;
        #1;
        chk("abort_async_terms", AW'(out_terms), AW'(0));
        chk("abort_async_sum", out_sum, '0);
        chk("abort_async_ready", AW'(in_ready), AW'(0));
        tick();
        rst_n = 1'b1;
        tick();
        exp_tot = '0;
        send_beat(WORD_W'(7), WORD_W'(9), 1'b1);
        exp_tot = exp_tot + AW'(16);
        check_result("after_abort", exp_tot, 16'd2, 1'b0);
        consume("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
